// File: rtl/ipu_poller.sv
`default_nettype none
// ============================================================================
// ipu_poller : periodic bus reader of the IPU position register; decodes it,
//              tracks object presence and exposes a 4-tap averaged cursor.
// Rev 1.0
// ============================================================================
module ipu_poller #(
   parameter logic [31:0] IPU_ADDR       = 32'h4000_0200,
   parameter int unsigned POLL_CYCLES    = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned LOST_COUNT     = 8
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        enable,
   output logic        read_o,
   output logic        write_o,
   output logic [31:0] addr_o,
   output logic [31:0] data_o,
   input  logic [31:0] data_i,
   input  logic        ack_i,
   output logic [9:0]  pos_row,
   output logic [9:0]  pos_col,
   output logic        pos_valid,
   output logic        tracking,
   output logic        lost,
   output logic [7:0]  timeout_cnt
);

   localparam int PW = $clog2(POLL_CYCLES);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [PW-1:0] c_POLL_LOAD = PW'(POLL_CYCLES - 1);
   localparam logic [TW-1:0] c_TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]    c_LOST      = 8'(LOST_COUNT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_CHECK = 2'd2,
      S_AVG   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    poll_cnt_q, poll_cnt_d;
   logic [TW-1:0]    req_cnt_q, req_cnt_d;
   logic [21:0]      rdata_q, rdata_d;
   logic [3:0][9:0]  tap_row_q, tap_row_d;
   logic [3:0][9:0]  tap_col_q, tap_col_d;
   logic [7:0]       lost_cnt_q, lost_cnt_d;
   logic             tracking_q, tracking_d;
   logic             lost_q, lost_d;
   logic             pos_valid_q, pos_valid_d;
   logic [9:0]       pos_row_q, pos_row_d;
   logic [9:0]       pos_col_q, pos_col_d;
   logic [7:0]       timeout_cnt_q, timeout_cnt_d;
   logic             read_q, read_d;
   logic [31:0]      addr_q, addr_d;

   logic             w_valid;
   logic             w_present;
   logic [9:0]       w_row;
   logic [9:0]       w_col;
   logic [7:0]       w_lost_inc;
   logic [11:0]      w_sum_row;
   logic [11:0]      w_sum_col;
   logic             w_unused_hi;

   // Upper status bits carry nothing of interest and are never stored.
   assign w_unused_hi = ^data_i[31:22];

   assign w_valid    = rdata_q[0];
   assign w_present  = rdata_q[1];
   assign w_col      = rdata_q[11:2];
   assign w_row      = rdata_q[21:12];
   assign w_lost_inc = (lost_cnt_q == 8'hFF) ? lost_cnt_q : lost_cnt_q + 8'd1;

   assign w_sum_row = {2'b00, tap_row_q[0]} + {2'b00, tap_row_q[1]}
                    + {2'b00, tap_row_q[2]} + {2'b00, tap_row_q[3]};
   assign w_sum_col = {2'b00, tap_col_q[0]} + {2'b00, tap_col_q[1]}
                    + {2'b00, tap_col_q[2]} + {2'b00, tap_col_q[3]};

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         poll_cnt_q    <= c_POLL_LOAD;
         req_cnt_q     <= '0;
         rdata_q       <= '0;
         tap_row_q     <= '0;
         tap_col_q     <= '0;
         lost_cnt_q    <= '0;
         tracking_q    <= 1'b0;
         lost_q        <= 1'b0;
         pos_valid_q   <= 1'b0;
         pos_row_q     <= '0;
         pos_col_q     <= '0;
         timeout_cnt_q <= '0;
         read_q        <= 1'b0;
         addr_q        <= '0;
      end else begin
         state_q       <= state_d;
         poll_cnt_q    <= poll_cnt_d;
         req_cnt_q     <= req_cnt_d;
         rdata_q       <= rdata_d;
         tap_row_q     <= tap_row_d;
         tap_col_q     <= tap_col_d;
         lost_cnt_q    <= lost_cnt_d;
         tracking_q    <= tracking_d;
         lost_q        <= lost_d;
         pos_valid_q   <= pos_valid_d;
         pos_row_q     <= pos_row_d;
         pos_col_q     <= pos_col_d;
         timeout_cnt_q <= timeout_cnt_d;
         read_q        <= read_d;
         addr_q        <= addr_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      poll_cnt_d    = poll_cnt_q;
      req_cnt_d     = req_cnt_q;
      rdata_d       = rdata_q;
      tap_row_d     = tap_row_q;
      tap_col_d     = tap_col_q;
      lost_cnt_d    = lost_cnt_q;
      tracking_d    = tracking_q;
      lost_d        = 1'b0;
      pos_valid_d   = 1'b0;
      pos_row_d     = pos_row_q;
      pos_col_d     = pos_col_q;
      timeout_cnt_d = timeout_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (poll_cnt_q != '0) begin
               poll_cnt_d = poll_cnt_q - PW'(1);
            end else if (enable) begin
               state_d   = S_REQ;
               req_cnt_d = '0;
            end
         end

         S_REQ: begin
            if (ack_i == 1'b1) begin
               rdata_d = data_i[21:0];
               state_d = S_CHECK;
            end else if (req_cnt_q == c_TO_LAST) begin
               state_d    = S_IDLE;
               poll_cnt_d = c_POLL_LOAD;
               if (timeout_cnt_q != 8'hFF) begin
                  timeout_cnt_d = timeout_cnt_q + 8'd1;
               end
            end else begin
               req_cnt_d = req_cnt_q + TW'(1);
            end
         end

         S_CHECK: begin
            state_d    = S_IDLE;
            poll_cnt_d = c_POLL_LOAD;
            if (w_valid) begin
               if (w_present) begin
                  // A fresh acquisition primes every tap so the first average is the sample itself.
                  if (tracking_q) begin
                     tap_row_d = {tap_row_q[2:0], w_row};
                     tap_col_d = {tap_col_q[2:0], w_col};
                  end else begin
                     tap_row_d = {4{w_row}};
                     tap_col_d = {4{w_col}};
                  end
                  lost_cnt_d = '0;
                  tracking_d = 1'b1;
                  state_d    = S_AVG;
               end else begin
                  lost_cnt_d = w_lost_inc;
                  if ((w_lost_inc == c_LOST) && tracking_q) begin
                     tracking_d = 1'b0;
                     lost_d     = 1'b1;
                  end
               end
            end
         end

         S_AVG: begin
            state_d     = S_IDLE;
            poll_cnt_d  = c_POLL_LOAD;
            pos_row_d   = w_sum_row[11:2];
            pos_col_d   = w_sum_col[11:2];
            pos_valid_d = 1'b1;
         end

         default: begin
            state_d    = S_IDLE;
            poll_cnt_d = c_POLL_LOAD;
         end
      endcase

      read_d = (state_d == S_REQ);
      addr_d = read_d ? IPU_ADDR : 32'd0;
   end

   assign read_o      = read_q;
   assign write_o     = 1'b0;
   assign addr_o      = addr_q;
   assign data_o      = 32'd0;
   assign pos_row     = pos_row_q;
   assign pos_col     = pos_col_q;
   assign pos_valid   = pos_valid_q;
   assign tracking    = tracking_q;
   assign lost        = lost_q;
   assign timeout_cnt = timeout_cnt_q;

endmodule
`default_nettype wire
